sobel_bram_port_arbiter: RTL

//  Owns one single-port frame BRAM shared by the host loader/reader and the Sobel/move engine.
//  - Host (bench/CPU) fills or reads the BRAM while idle.
//  - On start, hands the port to the engine and pulses its run input.
//  - Returns the port to the host on engine done and reports completion.
//  - One instance per BRAM (source BRAM0 and destination BRAM1) in the Sobel top level.

---
 rtl/sobel_bram_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sobel_bram_port_arbiter.sv
// sobel_bram_port_arbiter
//   Owns one single-port frame BRAM. The BRAM is shared between the host
//   (loader/reader) and the Sobel/move engine. The host owns the port while
//   idle. A start request hands the port to the engine and pulses e_run.
//   The port returns to the host once the engine reports done.
//
// Optional feature macro: SOBEL_ARB_TIMEOUT_EN
//   Adds a RUN-state watchdog of TIMEOUT_CYCLES cycles with a sticky o_err.
//   When the macro is undefined there is no watchdog and o_err is tied to 0.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   i_start, i_num_cnt         frame start pulse, pixel count latched at GRANT
//   o_idle, o_busy, o_done     FSM status; o_done pulses when the host regains the port
//   o_err                      sticky watchdog flag
//   o_h_stall                  host access attempted while the engine owns the port
//   h_ce, h_we, h_addr, h_d    host request; h_q is the host read data
//   e_run, e_num_cnt           engine start pulse and latched frame count
//   e_done                     engine completion, sampled only in RUN
//   e_ce, e_we, e_addr, e_d    engine request; e_q is the engine read data
//   m_ce, m_we, m_addr, m_d    BRAM request; m_q is the BRAM read data (1-cycle latency)
//
// Ownership handshake: exactly one requester owns m_* in any cycle, chosen
// by the registered sel_eng. The non-owner's requests are dropped, never
// queued. The owner sees read data one cycle after its ce, and the
// non-owner sees zeros. o_h_stall tells the host when its request was dropped.

module sobel_bram_port_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_num_cnt,
    output logic                  o_idle,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_h_stall,
    input  logic                  h_ce,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_d,
    output logic [DATA_WIDTH-1:0] h_q,
    output logic                  e_run,
    output logic [ADDR_WIDTH-1:0] e_num_cnt,
    input  logic                  e_done,
    input  logic                  e_ce,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_d,
    output logic [DATA_WIDTH-1:0] e_q,
    output logic                  m_ce,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_d,
    input  logic [DATA_WIDTH-1:0] m_q
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state;
    logic   pending;
    logic   sel_eng;    // 1: engine owns m_*, 0: host owns m_*
    logic   sel_eng_q;  // select delayed one cycle, steers m_q
    logic   timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pending   <= 1'b0;
            sel_eng   <= 1'b0;
            sel_eng_q <= 1'b0;
            e_num_cnt <= '0;
        end else begin
            sel_eng_q <= sel_eng;
            case (state)
                S_IDLE: begin
                    // A start that arrives while the host is mid-access waits in
                    // pending, so the host access in that cycle still completes.
                    if ((pending || i_start) && !h_ce) begin
                        state   <= S_GRANT;
                        sel_eng <= 1'b1;
                        pending <= 1'b0;
                    end else if (i_start) begin
                        pending <= 1'b1;
                    end
                end
                S_GRANT: begin
                    e_num_cnt <= i_num_cnt;
                    pending   <= 1'b0;
                    if (i_num_cnt == '0) begin
                        state   <= S_DONE;
                        sel_eng <= 1'b0;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (e_done || timeout_hit) state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // The engine keeps the port this cycle so that its last
                    // write and its last read data land.
                    state   <= S_DONE;
                    sel_eng <= 1'b0;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    sel_eng <= 1'b0;
                end
            endcase
        end
    end

`ifdef SOBEL_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        err_r;

    assign timeout_hit = (state == S_RUN) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_r  <= 1'b0;
        end else if (state == S_GRANT) begin
            wd_cnt <= '0;
            err_r  <= 1'b0;
        end else if (state == S_RUN && !e_done) begin
            if (timeout_hit) err_r  <= 1'b1;
            else             wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign o_err = err_r;
`else
    // There is no watchdog. This comparison is constant false.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign o_err       = 1'b0;
`endif

    assign o_idle    = (state == S_IDLE);
    assign o_busy    = (state == S_GRANT) || (state == S_RUN) || (state == S_RELEASE);
    assign o_done    = (state == S_DONE);
    assign e_run     = (state == S_GRANT) && (i_num_cnt != '0);

    assign m_ce      = sel_eng ? e_ce   : h_ce;
    assign m_we      = sel_eng ? e_we   : h_we;
    assign m_addr    = sel_eng ? e_addr : h_addr;
    assign m_d       = sel_eng ? e_d    : h_d;

    assign o_h_stall = h_ce & sel_eng;
    assign h_q       = sel_eng_q ? '0  : m_q;
    assign e_q       = sel_eng_q ? m_q : '0;

endmodule
